// File: rtl/regime_pkg.sv
// rtl/regime_pkg.sv - shared constants and types for the regime command sequencer
package regime_pkg;

  localparam logic [1:0] MODE_OFF   = 2'd0;
  localparam logic [1:0] MODE_ENUM  = 2'd1;
  localparam logic [1:0] MODE_COUNT = 2'd2;
  localparam logic [1:0] MODE_UPD   = 2'd3;

  localparam logic [1:0] REGIME_OFF = 2'd0;

  typedef enum logic [2:0] {
    SEQ_IDLE      = 3'd0,
    SEQ_ISSUE     = 3'd1,
    SEQ_HOLD      = 3'd2,
    SEQ_WAIT_DONE = 3'd3,
    SEQ_RESP      = 3'd4
  } seq_state_t;

  function automatic logic [7:0] sat_inc8(input logic [7:0] v, input logic en);
    if (en && (v != 8'hFF))
      return v + 8'd1;
    return v;
  endfunction

endpackage

// File: rtl/regime_cmd_fifo.sv
// rtl/regime_cmd_fifo.sv - command queue, DEPTH entries of {mode, len}
module regime_cmd_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 6
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic [W-1:0] wdata,
  input  logic         pop,
  output logic [W-1:0] rdata,
  output logic         full,
  output logic         empty
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;
  logic          do_push;
  logic          do_pop;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rdata   = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push)
      mem[wr_ptr] <= wdata;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push)
        wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)
        rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/regime_cmd_sequencer.sv
// rtl/regime_cmd_sequencer.sv - issues queued commands to the regime controller and reports completion
module regime_cmd_sequencer #(
  parameter int DEPTH   = 4,
  parameter int LEN_W   = 4,
  parameter int TIMEOUT = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_mode,
  input  logic [LEN_W-1:0] cmd_len,
  output logic [1:0]       on,
  output logic             start,
  input  logic [1:0]       regime,
  input  logic             active,
  input  logic [7:0]       y,
  input  logic [2:0]       s,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [1:0]       rsp_mode,
  output logic [7:0]       rsp_y,
  output logic [2:0]       rsp_s,
  output logic [7:0]       rsp_act_cnt,
  output logic             rsp_timeout,
  output logic             busy
);
  import regime_pkg::*;

  localparam logic [2:0] IDLE      = SEQ_IDLE;
  localparam logic [2:0] ISSUE     = SEQ_ISSUE;
  localparam logic [2:0] HOLD      = SEQ_HOLD;
  localparam logic [2:0] WAIT_DONE = SEQ_WAIT_DONE;
  localparam logic [2:0] RESP      = SEQ_RESP;

  localparam int          TW       = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);

  logic [2:0]       state;
  logic [1:0]       mode_r;
  logic [LEN_W-1:0] len_r;
  logic [LEN_W-1:0] hold_cnt;
  logic [7:0]       act_cnt;
  logic             seen_busy;
  logic [TW-1:0]    tmo_cnt;

  logic             fifo_full;
  logic             fifo_empty;
  logic [1:0]       fifo_mode;
  logic [LEN_W-1:0] fifo_len;
  logic             pop;
  logic             regime_busy;
  logic [7:0]       act_next;

  assign cmd_ready   = !fifo_full;
  assign regime_busy = (regime != REGIME_OFF);
  assign pop         = (state == IDLE) && !fifo_empty && !regime_busy;

  regime_cmd_fifo #(
    .DEPTH (DEPTH),
    .W     (2 + LEN_W)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (cmd_valid),
    .wdata ({cmd_mode, cmd_len}),
    .pop   (pop),
    .rdata ({fifo_mode, fifo_len}),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // ISSUE restarts the active count, so its own cycle is counted from zero
  always_comb begin
    act_next = sat_inc8((state == ISSUE) ? 8'd0 : act_cnt, active);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      mode_r      <= '0;
      len_r       <= '0;
      hold_cnt    <= '0;
      act_cnt     <= '0;
      seen_busy   <= 1'b0;
      tmo_cnt     <= '0;
      on          <= '0;
      start       <= 1'b0;
      busy        <= 1'b0;
      rsp_valid   <= 1'b0;
      rsp_mode    <= '0;
      rsp_y       <= '0;
      rsp_s       <= '0;
      rsp_act_cnt <= '0;
      rsp_timeout <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (pop) begin
            mode_r <= fifo_mode;
            len_r  <= fifo_len;
            on     <= fifo_mode;
            start  <= (fifo_mode != MODE_OFF) && (fifo_len != '0);
            busy   <= 1'b1;
            state  <= ISSUE;
          end
        end
        ISSUE: begin
          on <= '0;
          if (mode_r == MODE_OFF) begin
            start       <= 1'b0;
            rsp_valid   <= 1'b1;
            rsp_mode    <= mode_r;
            rsp_y       <= y;
            rsp_s       <= s;
            rsp_act_cnt <= '0;
            rsp_timeout <= 1'b0;
            state       <= RESP;
          end else begin
            act_cnt   <= act_next;
            seen_busy <= regime_busy;
            tmo_cnt   <= '0;
            hold_cnt  <= len_r - LEN_W'(1);
            if (len_r > LEN_W'(1)) begin
              start <= 1'b1;
              state <= HOLD;
            end else begin
              start <= 1'b0;
              state <= WAIT_DONE;
            end
          end
        end
        HOLD: begin
          act_cnt   <= act_next;
          seen_busy <= seen_busy | regime_busy;
          if (hold_cnt == LEN_W'(1)) begin
            start <= 1'b0;
            state <= WAIT_DONE;
          end else begin
            hold_cnt <= hold_cnt - LEN_W'(1);
          end
        end
        WAIT_DONE: begin
          act_cnt   <= act_next;
          seen_busy <= seen_busy | regime_busy;
          if ((seen_busy && !regime_busy) || (tmo_cnt == TMO_LAST)) begin
            rsp_valid   <= 1'b1;
            rsp_mode    <= mode_r;
            rsp_y       <= y;
            rsp_s       <= s;
            rsp_act_cnt <= act_next;
            rsp_timeout <= !(seen_busy && !regime_busy);
            state       <= RESP;
          end else begin
            tmo_cnt <= tmo_cnt + TW'(1);
          end
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            busy      <= 1'b0;
            state     <= IDLE;
          end
        end
        default: begin
          on    <= '0;
          start <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_regime_cmd_sequencer.sv
// tb/tb_regime_cmd_sequencer.sv - directed scoreboard bench for regime_cmd_sequencer
module tb_regime_cmd_sequencer;

  localparam int TIMEOUT = 16;

  typedef struct packed {
    logic [1:0] mode;
    logic [7:0] y;
    logic [2:0] s;
    logic [7:0] act;
    logic       tmo;
  } rsp_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       cmd_valid = 1'b0;
  logic       cmd_ready;
  logic [1:0] cmd_mode = '0;
  logic [3:0] cmd_len = '0;
  logic [1:0] on;
  logic       start;
  logic [1:0] regime = '0;
  logic       active = 1'b0;
  logic [7:0] y = '0;
  logic [2:0] s = '0;
  logic       rsp_valid;
  logic       rsp_ready = 1'b0;
  logic [1:0] rsp_mode;
  logic [7:0] rsp_y;
  logic [2:0] rsp_s;
  logic [7:0] rsp_act_cnt;
  logic       rsp_timeout;
  logic       busy;

  int checks = 0;
  int errors = 0;
  rsp_t exp_q[$];

  // controller model knobs, set by the stimulus block
  int         mdl_busy = 0;
  int         mdl_act = 0;
  logic [1:0] mdl_val = 2'd1;
  logic [7:0] mdl_y = '0;
  logic [2:0] mdl_s = '0;
  int         busy_left = 0;
  int         act_left = 0;

  int         cyc = 0;
  int         on_total = 0;
  int         start_total = 0;
  logic [1:0] last_on = '0;
  int         busy_rise_cyc = 0;
  int         rsp_rise_cyc = 0;
  logic       busy_q = 1'b0;
  logic       rsp_q = 1'b0;

  regime_cmd_sequencer #(
    .DEPTH   (4),
    .LEN_W   (4),
    .TIMEOUT (TIMEOUT)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .cmd_valid   (cmd_valid),
    .cmd_ready   (cmd_ready),
    .cmd_mode    (cmd_mode),
    .cmd_len     (cmd_len),
    .on          (on),
    .start       (start),
    .regime      (regime),
    .active      (active),
    .y           (y),
    .s           (s),
    .rsp_valid   (rsp_valid),
    .rsp_ready   (rsp_ready),
    .rsp_mode    (rsp_mode),
    .rsp_y       (rsp_y),
    .rsp_s       (rsp_s),
    .rsp_act_cnt (rsp_act_cnt),
    .rsp_timeout (rsp_timeout),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  // controller: an on pulse starts mdl_busy cycles of nonzero regime and mdl_act cycles of active
  always @(negedge clk) begin
    if (on === 2'd1 || on === 2'd2 || on === 2'd3) begin
      busy_left = mdl_busy;
      act_left  = mdl_act;
    end
    regime = (busy_left > 0) ? mdl_val : 2'd0;
    active = (act_left > 0);
    if (busy_left > 0) busy_left--;
    if (act_left > 0) act_left--;
    y = mdl_y;
    s = mdl_s;
  end

  always @(negedge clk) begin
    cyc++;
    if (on === 2'd1 || on === 2'd2 || on === 2'd3) begin
      on_total++;
      last_on = on;
    end
    if (start === 1'b1) start_total++;
    if (busy === 1'b1 && !busy_q) busy_rise_cyc = cyc;
    if (rsp_valid === 1'b1 && !rsp_q) rsp_rise_cyc = cyc;
    busy_q = (busy === 1'b1);
    rsp_q  = (rsp_valid === 1'b1);
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push_cmd(input logic [1:0] m, input logic [3:0] l);
    int n = 0;
    cmd_valid = 1'b1;
    cmd_mode  = m;
    cmd_len   = l;
    while (cmd_ready !== 1'b1 && n < 50) begin
      tick();
      n++;
    end
    if (cmd_ready !== 1'b1) begin
      checks++;
      errors++;
      $error("FAIL push_cmd cmd_ready observed=%0h expected=1", cmd_ready);
    end
    tick();
    cmd_valid = 1'b0;
  endtask

  task automatic wait_rsp(input string tag);
    int   n = 0;
    rsp_t e;
    while (rsp_valid !== 1'b1 && n < 300) begin
      tick();
      n++;
    end
    if (rsp_valid !== 1'b1) begin
      checks++;
      errors++;
      $error("FAIL %s rsp_valid observed=%0h expected=1", tag, rsp_valid);
    end else if (exp_q.size() == 0) begin
      checks++;
      errors++;
      $error("FAIL %s unexpected response observed_mode=%0h expected=none", tag, rsp_mode);
    end else begin
      e = exp_q.pop_front();
      chk({tag, "_mode"}, 32'(rsp_mode), 32'(e.mode));
      chk({tag, "_y"}, 32'(rsp_y), 32'(e.y));
      chk({tag, "_s"}, 32'(rsp_s), 32'(e.s));
      chk({tag, "_act"}, 32'(rsp_act_cnt), 32'(e.act));
      chk({tag, "_tmo"}, 32'(rsp_timeout), 32'(e.tmo));
      rsp_ready = 1'b1;
      tick();
      rsp_ready = 1'b0;
      chk({tag, "_valid_drop"}, 32'(rsp_valid), 32'd0);
    end
  endtask

  initial begin
    int on0;
    int st0;
    logic [1:0] b2b_modes [5];
    b2b_modes[0] = 2'd1;
    b2b_modes[1] = 2'd2;
    b2b_modes[2] = 2'd3;
    b2b_modes[3] = 2'd0;
    b2b_modes[4] = 2'd2;

    // power-on reset
    tick();
    tick();
    chk("rst_on", 32'(on), 32'd0);
    chk("rst_start", 32'(start), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_cmd_ready", 32'(cmd_ready), 32'd1);
    chk("rst_rsp_y", 32'(rsp_y), 32'd0);
    rst = 1'b0;
    tick();

    // reset in the middle of HOLD flushes the queued second command
    mdl_busy = 0;
    mdl_act  = 0;
    push_cmd(2'd2, 4'd5);
    push_cmd(2'd1, 4'd1);
    chk("mid_busy", 32'(busy), 32'd1);
    tick();
    tick();
    chk("mid_hold_start", 32'(start), 32'd1);
    rst = 1'b1;
    tick();
    chk("mid_rst_on", 32'(on), 32'd0);
    chk("mid_rst_start", 32'(start), 32'd0);
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_cmd_ready", 32'(cmd_ready), 32'd1);
    chk("mid_rst_rsp_valid", 32'(rsp_valid), 32'd0);
    rst = 1'b0;
    repeat (4) tick();
    chk("mid_no_replay_busy", 32'(busy), 32'd0);
    chk("mid_no_replay_rsp", 32'(rsp_valid), 32'd0);

    // mode 3, len 0: one on pulse, start stays low
    mdl_busy = 3; mdl_act = 0; mdl_val = 2'd3; mdl_y = 8'h5A; mdl_s = 3'd1;
    tick();
    on0 = on_total; st0 = start_total;
    exp_q.push_back('{mode: 2'd3, y: 8'h5A, s: 3'd1, act: 8'd0, tmo: 1'b0});
    push_cmd(2'd3, 4'd0);
    wait_rsp("m3_len0");
    chk("m3_on_cycles", 32'(on_total - on0), 32'd1);
    chk("m3_on_value", 32'(last_on), 32'd3);
    chk("m3_start_cycles", 32'(start_total - st0), 32'd0);

    // mode 1, len 3, four active cycles
    mdl_busy = 3; mdl_act = 4; mdl_val = 2'd1; mdl_y = 8'hC3; mdl_s = 3'd4;
    tick();
    on0 = on_total; st0 = start_total;
    exp_q.push_back('{mode: 2'd1, y: 8'hC3, s: 3'd4, act: 8'd4, tmo: 1'b0});
    push_cmd(2'd1, 4'd3);
    wait_rsp("m1_len3");
    chk("m1_start_cycles", 32'(start_total - st0), 32'd3);
    chk("m1_on_cycles", 32'(on_total - on0), 32'd1);

    // controller never leaves off: forced completion after TIMEOUT cycles in WAIT_DONE
    mdl_busy = 0; mdl_act = 0; mdl_y = 8'h11; mdl_s = 3'd7;
    tick();
    st0 = start_total;
    exp_q.push_back('{mode: 2'd2, y: 8'h11, s: 3'd7, act: 8'd0, tmo: 1'b1});
    push_cmd(2'd2, 4'd2);
    wait_rsp("timeout");
    chk("timeout_latency", 32'(rsp_rise_cyc - busy_rise_cyc), 32'(TIMEOUT + 2));
    chk("timeout_start_cycles", 32'(start_total - st0), 32'd2);

    // mode 0: immediate response, controller untouched
    mdl_busy = 0; mdl_act = 0; mdl_y = 8'hA5; mdl_s = 3'd6;
    tick();
    on0 = on_total; st0 = start_total;
    exp_q.push_back('{mode: 2'd0, y: 8'hA5, s: 3'd6, act: 8'd0, tmo: 1'b0});
    push_cmd(2'd0, 4'd7);
    wait_rsp("m0");
    chk("m0_latency", 32'(rsp_rise_cyc - busy_rise_cyc), 32'd1);
    chk("m0_on_cycles", 32'(on_total - on0), 32'd0);
    chk("m0_start_cycles", 32'(start_total - st0), 32'd0);

    // five back-to-back pushes with the response port stalled
    mdl_busy = 2; mdl_act = 0; mdl_val = 2'd1; mdl_y = 8'h3C; mdl_s = 3'd2;
    tick();
    tick();
    for (int i = 0; i < 5; i++) begin
      cmd_valid = 1'b1;
      cmd_mode  = b2b_modes[i];
      cmd_len   = 4'd1;
      chk($sformatf("b2b_ready_%0d", i), 32'(cmd_ready), 32'd1);
      exp_q.push_back('{mode: b2b_modes[i], y: 8'h3C, s: 3'd2, act: 8'd0, tmo: 1'b0});
      tick();
    end
    cmd_valid = 1'b0;
    chk("b2b_full", 32'(cmd_ready), 32'd0);
    repeat (12) tick();
    chk("b2b_held_valid", 32'(rsp_valid), 32'd1);
    chk("b2b_held_mode", 32'(rsp_mode), 32'd1);
    chk("b2b_held_full", 32'(cmd_ready), 32'd0);
    for (int i = 0; i < 5; i++)
      wait_rsp($sformatf("b2b_%0d", i));
    repeat (4) tick();
    chk("b2b_idle", 32'(busy), 32'd0);
    chk("b2b_queue_empty", 32'(exp_q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
